// File: rtl/pref_pkg.sv
// pref_pkg: address types and constants shared by the prefetcher and its issue queue
package pref_pkg;
  localparam int ADDR_SIZE = 64;
  localparam int LOG2_BLOCK_SIZE = 6;
  localparam int LOG2_PAGE_SIZE = 12;
  typedef logic [ADDR_SIZE-1:0] addr_t;
  function automatic addr_t block_align(addr_t a);
    return {a[ADDR_SIZE-1:LOG2_BLOCK_SIZE], {LOG2_BLOCK_SIZE{1'b0}}};
  endfunction
endpackage

// File: rtl/pref_filter.sv
// pref_filter: recent-issue CAM; three parallel lookups (lookup_i -> hit_o), one round-robin insert (ins_valid_i/ins_addr_i)
module pref_filter
  import pref_pkg::*;
#(
  parameter int FILTER_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  addr_t      lookup_i [3],
  output logic [2:0] hit_o,
  input  logic       ins_valid_i,
  input  addr_t      ins_addr_i
);
  localparam int FW = FILTER_SIZE > 1 ? $clog2(FILTER_SIZE) : 1;
  addr_t addr_q [FILTER_SIZE];
  addr_t addr_d [FILTER_SIZE];
  logic [FILTER_SIZE-1:0] vld_q, vld_d;
  logic [FW-1:0] ptr_q, ptr_d;
  always_comb begin
    hit_o = '0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < FILTER_SIZE; i++)
        if (vld_q[i] && addr_q[i] == lookup_i[k]) hit_o[k] = 1'b1;
    addr_d = addr_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (ins_valid_i) begin
      addr_d[ptr_q] = ins_addr_i;
      vld_d[ptr_q] = 1'b1;
      ptr_d = (ptr_q == FW'(FILTER_SIZE - 1)) ? '0 : ptr_q + FW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FILTER_SIZE; i++) addr_q[i] <= '0;
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      addr_q <= addr_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/pref_issue_queue.sv
// pref_issue_queue: dedups three prefetch candidates per cycle, queues survivors in order, issues one per cycle
// Ports: pref_addr{1,2,3}_i/pref_valid{1,2,3}_i candidates; req_addr_o/req_valid_o/req_ready_i issue handshake;
//        queue_count_o occupancy; drop_count_o saturating count of new candidates lost to a full queue.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int QUEUE_DEPTH = 8,
  parameter int FILTER_SIZE = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_SIZE-1:0]           pref_addr1_i,
  input  logic                           pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]           pref_addr2_i,
  input  logic                           pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]           pref_addr3_i,
  input  logic                           pref_valid3_i,
  output logic [ADDR_SIZE-1:0]           req_addr_o,
  output logic                           req_valid_o,
  input  logic                           req_ready_i,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o,
  output logic [CNT_WIDTH-1:0]           drop_count_o
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  addr_t mem_q [QUEUE_DEPTH];
  addr_t mem_d [QUEUE_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, off;
  logic [CW-1:0] count_q, count_d, space, pushes;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  addr_t cand [3];
  logic [2:0] vin, fhit, qhit, dup, newc;
  logic pop;
  always_comb begin
    cand[0] = block_align(pref_addr1_i);
    cand[1] = block_align(pref_addr2_i);
    cand[2] = block_align(pref_addr3_i);
    vin = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  end
  pref_filter #(.FILTER_SIZE(FILTER_SIZE)) u_filter (
    .clk        (clk),
    .rst        (rst),
    .lookup_i   (cand),
    .hit_o      (fhit),
    .ins_valid_i(pop),
    .ins_addr_i (mem_q[head_q])
  );
  assign req_valid_o = count_q != '0;
  assign req_addr_o = req_valid_o ? mem_q[head_q] : '0;
  assign queue_count_o = count_q;
  assign drop_count_o = drop_q;
  assign pop = req_valid_o & req_ready_i;
  always_comb begin
    qhit = '0;
    dup = '0;
    off = '0;
    // queue compare uses pre-pop contents, so the entry being popped still blocks a duplicate
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        off = PW'(i) - head_q;
        if ({1'b0, off} < count_q && mem_q[i] == cand[k]) qhit[k] = 1'b1;
      end
      for (int j = 0; j < k; j++)
        if (vin[j] && cand[j] == cand[k]) dup[k] = 1'b1;
    end
    newc = vin & ~qhit & ~dup & ~fhit;
    space = CW'(QUEUE_DEPTH) - count_q + CW'(pop);
    pushes = '0;
    mem_d = mem_q;
    tail_d = tail_q;
    drop_d = drop_q;
    for (int k = 0; k < 3; k++) begin
      if (newc[k] && pushes < space) begin
        mem_d[tail_d] = cand[k];
        tail_d = tail_d + PW'(1);
        pushes = pushes + CW'(1);
      end else if (newc[k]) begin
        drop_d = &drop_d ? drop_d : drop_d + CNT_WIDTH'(1);
      end
    end
    head_d = head_q + PW'(pop);
    count_d = count_q + pushes - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      drop_q <= '0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_pref_issue_queue.sv
// tb_pref_issue_queue: directed checks of dedup, ordering, filter aging, full-queue drops and async reset
module tb_pref_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] a1 = '0, a2 = '0, a3 = '0;
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic ready = 1'b0;
  logic [63:0] req_addr;
  logic req_valid;
  logic [3:0] qcount;
  logic [31:0] drops;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pref_issue_queue dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(a1), .pref_valid1_i(v1),
    .pref_addr2_i(a2), .pref_valid2_i(v2),
    .pref_addr3_i(a3), .pref_valid3_i(v3),
    .req_addr_o(req_addr), .req_valid_o(req_valid), .req_ready_i(ready),
    .queue_count_o(qcount), .drop_count_o(drops)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cands(input logic [63:0] x1, input logic e1, input logic [63:0] x2, input logic e2,
                       input logic [63:0] x3, input logic e3);
    a1 = x1; v1 = e1; a2 = x2; v2 = e2; a3 = x3; v3 = e3;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_count", 64'(qcount), 64'd0);
    chk("rst_drop", 64'(drops), 64'd0);
    chk("rst_addr", req_addr, 64'd0);
    #10 rst = 1'b0;
    tick();
    // single candidate, aligned on entry
    cands(64'h1047, 1, 0, 0, 0, 0);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("single_valid", 64'(req_valid), 64'd1);
    chk("single_addr", req_addr, 64'h1040);
    chk("single_count", 64'(qcount), 64'd1);
    ready = 1; tick(); ready = 0;
    chk("single_pop_count", 64'(qcount), 64'd0);
    chk("single_pop_valid", 64'(req_valid), 64'd0);
    // ordering of three candidates in one cycle
    cands(64'h2000, 1, 64'h2040, 1, 64'h2080, 1);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("order_count", 64'(qcount), 64'd3);
    chk("order_head0", req_addr, 64'h2000);
    ready = 1; tick();
    chk("order_head1", req_addr, 64'h2040);
    tick();
    chk("order_head2", req_addr, 64'h2080);
    tick(); ready = 0;
    chk("order_empty", 64'(qcount), 64'd0);
    // same block in one cycle, then against a queued entry
    cands(64'h3000, 1, 64'h3010, 1, 0, 0);
    tick();
    chk("dedup_count", 64'(qcount), 64'd1);
    chk("dedup_drop", 64'(drops), 64'd0);
    cands(64'h3000, 1, 0, 0, 0, 0);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("dedup_queue_count", 64'(qcount), 64'd1);
    ready = 1; tick(); ready = 0;
    // empty with ready high must not disturb anything
    ready = 1; tick(); ready = 0;
    chk("empty_ready_count", 64'(qcount), 64'd0);
    // filter blocks a recently issued address
    cands(64'h4000, 1, 0, 0, 0, 0);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    ready = 1; tick(); ready = 0;
    chk("filter_issue_count", 64'(qcount), 64'd0);
    cands(64'h4000, 1, 0, 0, 0, 0);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("filter_block_count", 64'(qcount), 64'd0);
    chk("filter_block_drop", 64'(drops), 64'd0);
    // sixteen further distinct issues age 0x4000 out
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      cands(64'h10000 + 64'(i) * 64'h40, 1, 0, 0, 0, 0);
      tick();
    end
    cands(0, 0, 0, 0, 0, 0);
    tick();
    ready = 0;
    chk("filter_stream_count", 64'(qcount), 64'd0);
    cands(64'h4000, 1, 0, 0, 0, 0);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("filter_aged_count", 64'(qcount), 64'd1);
    chk("filter_aged_addr", req_addr, 64'h4000);
    ready = 1; tick(); ready = 0;
    // fill to full, overflow counted
    for (int c = 0; c < 3; c++) begin
      cands(64'h50000 + 64'(c) * 64'h100, 1, 64'h50040 + 64'(c) * 64'h100, 1,
            64'h50080 + 64'(c) * 64'h100, 1);
      tick();
    end
    cands(0, 0, 0, 0, 0, 0);
    chk("full_count", 64'(qcount), 64'd8);
    chk("full_drop", 64'(drops), 64'd1);
    chk("full_head_stable", req_addr, 64'h50000);
    tick();
    chk("full_hold_addr", req_addr, 64'h50000);
    chk("full_hold_valid", 64'(req_valid), 64'd1);
    ready = 1;
    cands(64'h60000, 1, 64'h60040, 1, 64'h60080, 1);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("full_pop_count", 64'(qcount), 64'd8);
    chk("full_pop_drop", 64'(drops), 64'd3);
    chk("full_pop_head", req_addr, 64'h50040);
    tick(); tick();
    ready = 0;
    chk("pre_reset_count", 64'(qcount), 64'd6);
    ready = 1; tick(); ready = 0;
    chk("pre_reset_count5", 64'(qcount), 64'd5);
    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(req_valid), 64'd0);
    chk("arst_count", 64'(qcount), 64'd0);
    chk("arst_drop", 64'(drops), 64'd0);
    chk("arst_addr", req_addr, 64'd0);
    #1 rst = 1'b0;
    cands(64'h4000, 1, 0, 0, 0, 0);
    tick();
    cands(0, 0, 0, 0, 0, 0);
    chk("post_reset_count", 64'(qcount), 64'd1);
    chk("post_reset_addr", req_addr, 64'h4000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pref_issue_queue.md
Name: pref_issue_queue

Overview:
Consumer end of the IP-stride prefetcher's three-candidate output interface. Each cycle it takes up to three block-aligned prefetch candidates and removes duplicates (within the cycle, against queued entries, and against recently issued addresses). It buffers survivors in an in-order FIFO and issues them one per cycle to the cache/memory side over a valid/ready handshake.

Parameters:
QUEUE_DEPTH, 8, FIFO entries; power of two, >= 4.
FILTER_SIZE, 16, number of recently issued block addresses remembered; round-robin replacement.
CNT_WIDTH, 32, width of the saturating drop counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
pref_addr1_i  in  64  candidate 1 byte address
pref_valid1_i  in  1  candidate 1 valid
pref_addr2_i  in  64  candidate 2 byte address
pref_valid2_i  in  1  candidate 2 valid
pref_addr3_i  in  64  candidate 3 byte address
pref_valid3_i  in  1  candidate 3 valid
req_addr_o  out  64  head-of-queue block address (low LOG2_BLOCK_SIZE bits zero)
req_valid_o  out  1  queue non-empty
req_ready_i  in  1  downstream accepts req_addr_o this cycle
queue_count_o  out  $clog2(QUEUE_DEPTH)+1  current occupancy
drop_count_o  out  CNT_WIDTH  candidates lost because the queue was full; saturates at all-ones

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst. While rst is high: queue empty, pointers 0, all filter entries invalid, filter pointer 0, req_valid_o=0, req_addr_o=0, queue_count_o=0, drop_count_o=0. Outputs take these values immediately, without waiting for a clock edge.
- Alignment: each candidate is cleared in bits [LOG2_BLOCK_SIZE-1:0] before any compare or storage.
- Pop: pop = req_valid_o & req_ready_i. On pop the head advances at the next edge. The popped address is written into the filter slot at the filter pointer, with valid=1, and the pointer increments modulo FILTER_SIZE.
- Candidate processing order is 1, 2, 3. A candidate is "new" when all of the following hold:
  - its valid is 1;
  - its aligned address differs from every earlier valid candidate in the same cycle;
  - it matches no valid queue entry, using pre-pop contents (so a candidate equal to the head being popped is dropped);
  - it matches no valid filter entry, using pre-update contents.
- Free space this cycle = QUEUE_DEPTH - count + pop. New candidates enqueue in order while space remains. Each remaining new candidate increments drop_count_o, saturating. Non-new candidates never touch drop_count_o.
- Latency: a candidate enqueued at edge N appears at req_valid_o/req_addr_o no earlier than after edge N, i.e. visible in cycle N+1. There is no input-to-output bypass.
- req_addr_o is held stable while req_valid_o=1 and req_ready_i=0. req_valid_o never drops without a pop or reset.
- Count update: count_next = count + pushes - pop, range 0..QUEUE_DEPTH. Pointers wrap modulo QUEUE_DEPTH.
- Empty with req_ready_i=1: no pop, no filter write.
- Full with a pop and three new candidates in the same cycle: exactly one enqueues, two are counted as drops.
- Reset asserted mid-operation discards all queued and filter state. No partial issue is retained.

Decomposition:
- Shared package pref_pkg holds ADDR_SIZE=64, LOG2_BLOCK_SIZE=6, LOG2_PAGE_SIZE=12, addr_t, and a block_align() function. These are shared with the prefetcher.
- One sub-module, pref_filter: a FILTER_SIZE-entry recent-issue CAM with a lookup port (three parallel compares) and an insert port, using round-robin replacement.
- FIFO storage and the dedup/enqueue logic stay in pref_issue_queue.

Test Plan:
1. Single candidate: after reset, pref_valid1_i=1, addr 0x1047 for one cycle, req_ready_i=0 -> next cycle req_valid_o=1, req_addr_o=0x1040, queue_count_o=1. Raising req_ready_i for one cycle -> queue_count_o=0, req_valid_o=0.
2. Ordering: one cycle with 0x2000/0x2040/0x2080 all valid, ready=0 -> count=3. With ready=1, issue order is 0x2000, 0x2040, 0x2080 on consecutive cycles.
3. Dedup: candidate 1 = 0x3000 and candidate 2 = 0x3010, both valid, one cycle -> count=1, drop_count_o=0. Repeating 0x3000 next cycle -> count stays 1.
4. Filter: issue 0x4000 (pop), then present 0x4000 -> not enqueued, drop_count_o unchanged. After FILTER_SIZE further distinct issues, 0x4000 is accepted again.
5. Full: QUEUE_DEPTH=8, ready=0, three distinct new candidates per cycle for 3 cycles -> count=8, drop_count_o=1. Fourth cycle, ready=1 with three new candidates -> one enqueued, drop_count_o=3.
6. Async reset: with count=5 and req_valid_o=1, assert rst between clock edges -> req_valid_o=0, queue_count_o=0, drop_count_o=0 before the next edge. After deassert, a previously issued address is accepted again because the filter is cleared.
